mips_fetch_stage: RTL and testbench

MIPS_FETCH_STAGE -- requirements
Module: mips_fetch_stage

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mips_fetch_if.sv | 45 ++++
 rtl/mips_pc_reg.sv | 18 +
 rtl/mips_fetch_stage.sv | 114 +++++++++++
 tb/tb_mips_fetch_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage:
// FSM encoding, memory map defaults and the NOP word.
package mips_pkg;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } fetch_state_t;

   localparam int          MEM_SIZE_DEF = 512;
   localparam int          EXC_ADDR_DEF = MEM_SIZE_DEF - 120;
   localparam logic [31:0] NOP          = 32'h0;

   function automatic logic [31:0] pc_plus4(
      input logic [31:0] pc
   );
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Fetch-stage bus: instruction memory, ID control
// inputs and the IF/ID pipeline register outputs.
interface mips_fetch_if;

   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        exc_req;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [31:0] epc;
   logic        fetch_fault;

   modport master (
      output PC,
      input  Instruction,
      input  stall,
      input  branch_taken,
      input  branch_target,
      input  exc_req,
      output if_id_inst,
      output if_id_pc4,
      output if_id_valid,
      output epc,
      output fetch_fault
   );

   modport slave (
      input  PC,
      output Instruction,
      output stall,
      output branch_taken,
      output branch_target,
      output exc_req,
      input  if_id_inst,
      input  if_id_pc4,
      input  if_id_valid,
      input  epc,
      input  fetch_fault
   );

endinterface

// File: rtl/mips_pc_reg.sv
// Program counter register with asynchronous
// active-low reset and a load enable.
module mips_pc_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] d,
   output logic [31:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q <= 32'h0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS IF stage: PC sequencing, redirect/exception
// vectoring, fetch-fault detection and IF/ID register.
import mips_pkg::*;

module mips_fetch_stage #(
   parameter int MEM_SIZE = MEM_SIZE_DEF,
   parameter int EXC_ADDR = MEM_SIZE - 120
) (
   input logic          clk,
   input logic          reset,
   mips_fetch_if.master f
);

   localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);
   localparam logic [31:0] EXC_PC  = 32'(EXC_ADDR);

   fetch_state_t state, state_nx;
   logic [31:0]  pc, pc_nx, pc4;
   logic         pc_en;
   logic [31:0]  inst_q, inst_nx;
   logic [31:0]  pc4_q, pc4_nx;
   logic [31:0]  epc_q, epc_nx;
   logic         valid_q, valid_nx;
   logic         fault_q, fault_nx;
   logic         fault;

   mips_pc_reg u_pc (
      .clk   (clk),
      .reset (reset),
      .en    (pc_en),
      .d     (pc_nx),
      .q     (pc)
   );

   assign pc4   = pc_plus4(pc);
   assign fault = (pc[1:0] != 2'b00) ||
                  (pc > LAST_PC);

   always_comb begin
      state_nx = state;
      pc_en    = 1'b1;
      pc_nx    = pc4;
      inst_nx  = inst_q;
      pc4_nx   = pc4_q;
      valid_nx = valid_q;
      epc_nx   = epc_q;
      fault_nx = 1'b0;
      unique case (state)
         BOOT: begin
            inst_nx  = f.Instruction;
            pc4_nx   = pc4;
            valid_nx = 1'b1;
            state_nx = RUN;
         end
         REDIRECT: begin
            // handler fetch ignores stall; exc re-vectors without epc
            if (f.exc_req) begin
               pc_nx    = EXC_PC;
               valid_nx = 1'b0;
            end else begin
               inst_nx  = f.Instruction;
               pc4_nx   = pc4;
               valid_nx = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (f.exc_req || fault) begin
               pc_nx    = EXC_PC;
               valid_nx = 1'b0;
               epc_nx   = pc;
               fault_nx = !f.exc_req;
               state_nx = REDIRECT;
            end else if (f.branch_taken) begin
               pc_nx    = f.branch_target;
               valid_nx = 1'b0;
            end else if (f.stall) begin
               pc_en    = 1'b0;
            end else begin
               inst_nx  = f.Instruction;
               pc4_nx   = pc4;
               valid_nx = 1'b1;
            end
         end
         default: state_nx = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= BOOT;
         inst_q  <= NOP;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
         epc_q   <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_nx;
         inst_q  <= inst_nx;
         pc4_q   <= pc4_nx;
         valid_q <= valid_nx;
         epc_q   <= epc_nx;
         fault_q <= fault_nx;
      end
   end

   assign f.PC          = pc;
   assign f.if_id_inst  = inst_q;
   assign f.if_id_pc4   = pc4_q;
   assign f.if_id_valid = valid_q;
   assign f.epc         = epc_q;
   assign f.fetch_fault = fault_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage with a
// behavioural fetch model checked every cycle.
module tb_mips_fetch_stage;
   import mips_pkg::*;

   localparam int          MEM  = 512;
   localparam logic [31:0] EXC  = 32'd392;
   localparam logic [31:0] LAST = 32'd508;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   mips_fetch_if bus ();

   mips_fetch_stage dut (
      .clk   (clk),
      .reset (reset),
      .f     (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [128];
   int n_cmp = 0;
   int n_bad = 0;

   always_comb begin
      if (bus.PC < 32'(MEM) && bus.PC[1:0] == 2'b00)
         bus.Instruction = mem[bus.PC[8:2]];
      else
         bus.Instruction = 32'hDEAD_BEEF;
   end

   function automatic logic [31:0] word_at(
      input logic [31:0] a
   );
      if (a < 32'(MEM) && a[1:0] == 2'b00)
         return mem[a[8:2]];
      return 32'hDEAD_BEEF;
   endfunction

   // model: what the IF/ID outputs must be
   logic [31:0] m_pc, m_inst, m_pc4, m_epc;
   logic        m_valid, m_fault;
   bit          m_boot, m_redir;
   logic        m_bad;

   assign m_bad = (m_pc % 4 != 0) || (m_pc > LAST);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc    <= 0;
         m_inst  <= 0;
         m_pc4   <= 0;
         m_valid <= 0;
         m_epc   <= 0;
         m_fault <= 0;
         m_boot  <= 1;
         m_redir <= 0;
      end else begin
         m_fault <= 0;
         if (m_boot || (m_redir && !bus.exc_req)
             || (!m_redir && !bus.exc_req && !m_bad
                 && !bus.branch_taken && !bus.stall)) begin
            m_inst  <= word_at(m_pc);
            m_pc4   <= m_pc + 4;
            m_valid <= 1;
            m_pc    <= m_pc + 4;
            m_boot  <= 0;
            m_redir <= 0;
         end else if (m_redir) begin
            m_pc    <= EXC;
            m_valid <= 0;
         end else if (bus.exc_req || m_bad) begin
            m_epc   <= m_pc;
            m_fault <= !bus.exc_req;
            m_pc    <= EXC;
            m_valid <= 0;
            m_redir <= 1;
         end else if (bus.branch_taken) begin
            m_pc    <= bus.branch_target;
            m_valid <= 0;
         end
      end
   end

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m.PC", bus.PC, m_pc);
      chk("m.inst", bus.if_id_inst, m_inst);
      chk("m.pc4", bus.if_id_pc4, m_pc4);
      chk("m.valid", 32'(bus.if_id_valid), 32'(m_valid));
      chk("m.epc", bus.epc, m_epc);
      chk("m.fault", 32'(bus.fetch_fault), 32'(m_fault));
   end

   task automatic step(
      input bit          s,
      input bit          b,
      input logic [31:0] t,
      input bit          e
   );
      bus.stall         = s;
      bus.branch_taken  = b;
      bus.branch_target = t;
      bus.exc_req       = e;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.stall         = 0;
      bus.branch_taken  = 0;
      bus.branch_target = 0;
      bus.exc_req       = 0;
      for (int i = 0; i < 128; i++)
         mem[i] = 32'hA000_0000 | 32'(i << 2);
      mem[0] = 32'h2005_0005;
      #1 reset = 0;
      #11;
      chk("rst.PC", bus.PC, 0);
      chk("rst.valid", 32'(bus.if_id_valid), 0);
      chk("rst.epc", bus.epc, 0);
      @(posedge clk);
      #1 reset = 1;

      step(0, 0, 0, 0);
      chk("seq.inst", bus.if_id_inst, 32'h2005_0005);
      chk("seq.pc4", bus.if_id_pc4, 4);
      chk("seq.valid", 32'(bus.if_id_valid), 1);
      chk("seq.PC", bus.PC, 4);
      step(0, 0, 0, 0);
      chk("seq2.PC", bus.PC, 8);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         chk("stall.PC", bus.PC, 8);
         chk("stall.inst", bus.if_id_inst, 32'hA000_0004);
         chk("stall.pc4", bus.if_id_pc4, 8);
      end
      step(0, 0, 0, 0);
      chk("resume.PC", bus.PC, 12);

      step(1, 1, 32'h40, 0);
      chk("br.PC", bus.PC, 32'h40);
      chk("br.valid", 32'(bus.if_id_valid), 0);
      step(0, 0, 0, 0);
      chk("br.inst", bus.if_id_inst, 32'hA000_0040);
      chk("br.pc4", bus.if_id_pc4, 32'h44);

      step(0, 1, 32'h10, 0);
      step(0, 1, 32'h80, 1);
      chk("pri.PC", bus.PC, 392);
      chk("pri.epc", bus.epc, 32'h10);
      chk("pri.fault", 32'(bus.fetch_fault), 0);
      step(1, 0, 0, 0);
      chk("redir.inst", bus.if_id_inst, 32'hA000_0188);
      chk("redir.pc4", bus.if_id_pc4, 396);

      step(0, 1, 32'h202, 0);
      chk("mis.PC", bus.PC, 32'h202);
      step(0, 0, 0, 0);
      chk("mis.fault", 32'(bus.fetch_fault), 1);
      chk("mis.epc", bus.epc, 32'h202);
      chk("mis.PC2", bus.PC, 392);
      chk("mis.valid", 32'(bus.if_id_valid), 0);
      step(0, 0, 0, 0);
      chk("mis.fault0", 32'(bus.fetch_fault), 0);
      chk("mis.valid1", 32'(bus.if_id_valid), 1);

      step(0, 1, 32'h1FC, 0);
      step(0, 0, 0, 0);
      chk("edge.inst", bus.if_id_inst, 32'hA000_01FC);
      chk("edge.fault", 32'(bus.fetch_fault), 0);
      step(0, 0, 0, 0);
      chk("oob.fault", 32'(bus.fetch_fault), 1);
      chk("oob.epc", bus.epc, 32'h200);
      step(0, 0, 0, 1);
      chk("nest.epc", bus.epc, 32'h200);
      chk("nest.valid", 32'(bus.if_id_valid), 0);
      step(0, 0, 0, 0);
      chk("nest.inst", bus.if_id_inst, 32'hA000_0188);

      step(0, 1, 32'h3, 0);
      step(0, 0, 0, 0);
      #1 reset = 0;
      #1;
      chk("rr.PC", bus.PC, 0);
      chk("rr.inst", bus.if_id_inst, 0);
      chk("rr.pc4", bus.if_id_pc4, 0);
      chk("rr.epc", bus.epc, 0);
      chk("rr.fault", 32'(bus.fetch_fault), 0);
      @(posedge clk);
      #1 reset = 1;
      step(0, 0, 0, 0);
      chk("rr.boot", bus.if_id_inst, 32'h2005_0005);
      chk("rr.PC4", bus.PC, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
